multicycle_controller: RTL

Main control FSM for the multicycle variant of the MIPS core. It sequences a shared-memory datapath (one ALU, one memory port, instruction register) through fetch, decode, execute, memory and writeback steps. It drives every mux select and write enable, and it derives ALU_control from Op/Funct. It sits beside the datapath and takes Op/Funct from the instruction register and Zero from the ALU.

---
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Optional feature macro: MC_BNE_EN adds bne, which shares the BRANCH state with beq.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Reg_write,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALU_control,
  output logic       Instr_done
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     out_state;
  logic       mem_state, wait_done, op_known, is_bne;
  logic       pc_write, branch;
  logic [2:0] funct_alu;

  assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign wait_done = (cnt_q == WAIT_LAST);

`ifdef MC_BNE_EN
  assign is_bne = (Op == OP_BNE);
`else
  assign is_bne = 1'b0;
`endif

  assign op_known = (Op == OP_LW) || (Op == OP_SW) || (Op == OP_RTYPE) || (Op == OP_BEQ) ||
                    (Op == OP_ADDI) || (Op == OP_J) || is_bne;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs only inside a memory state and drops to 0 on leaving, so every entry starts at 0.
  always_comb begin
    cnt_d   = (mem_state && !wait_done) ? cnt_q + 4'd1 : 4'd0;
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = wait_done ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (Op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = wait_done ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = wait_done ? FETCH : MEMWRITE;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEX:   state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  end

  // During reset the selects show FETCH values and every write-type output is held low.
  assign out_state = Reset ? FETCH : state_q;

  always_comb begin
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    Reg_write   = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    ALU_control = 3'b000;
    Instr_done  = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    case (out_state)
      FETCH: begin
        ALUSrcB     = 2'b01;
        ALU_control = ALU_ADD;
        IRWrite     = wait_done;
        pc_write    = wait_done;
      end
      DECODE: begin
        ALUSrcB     = 2'b11;
        ALU_control = ALU_ADD;
        Instr_done  = !op_known;
      end
      MEMADR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_control = ALU_ADD;
      end
      MEMREAD:  IorD = 1'b1;
      MEMWB: begin
        MemtoReg   = 1'b1;
        Reg_write  = 1'b1;
        Instr_done = 1'b1;
      end
      MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        Instr_done = wait_done;
      end
      EXECUTE: begin
        ALUSrcA     = 1'b1;
        ALU_control = funct_alu;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        Reg_write  = 1'b1;
        Instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_control = ALU_SUB;
        PCSrc       = 2'b01;
        branch      = 1'b1;
        Instr_done  = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_control = ALU_ADD;
      end
      ADDIWB: begin
        Reg_write  = 1'b1;
        Instr_done = 1'b1;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        Instr_done = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      Reg_write  = 1'b0;
      Instr_done = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
    end
  end

  assign PCEn = pc_write | (branch & (Zero ^ is_bne));

endmodule
